// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
// Avalon-MM master that owns the 16-bit interval timer. It programs the period,
// starts the timer in continuous/interrupt mode, clears each irq, and turns
// serviced irqs into one-cycle game ticks. It also handles pause/resume and
// runtime period reloads.
// Optional feature macro: GAME_TICK_PRESCALE_EN (one tick per TICK_DIV irqs).
module game_tick_scheduler #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h004C4B3F,
    parameter logic [31:0] PERIOD_MIN     = 32'd100,
    parameter int          TICK_DIV       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_en,
    input  logic [31:0] cfg_period,
    input  logic        cfg_load,
    output logic [2:0]  tm_address,
    output logic        tm_chipselect,
    output logic        tm_write_n,
    output logic [15:0] tm_writedata,
    input  logic        tm_irq,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        busy,
    output logic        running
);

    typedef enum logic [2:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_START,
        RUN,
        CLR,
        SETTLE,
        WR_STOP
    } state_t;

    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  ADDR_PERIODH = 3'd3;
    localparam logic [15:0] CTRL_START   = 16'h0007;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;

    // A divider below one makes no sense for the prescaled build either.
    if (TICK_DIV < 1) begin : g_tick_div_invalid
        $error("TICK_DIV must be at least 1");
    end

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        pend_load_q, pend_load_d;
    logic [2:0]  tm_address_q, tm_address_d;
    logic        tm_chipselect_q, tm_chipselect_d;
    logic        tm_write_n_q, tm_write_n_d;
    logic [15:0] tm_writedata_q, tm_writedata_d;
    logic        tick_q, tick_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic        busy_q, busy_d;
    logic        running_q, running_d;

    // Sequencer: programming, irq service and stop paths of the timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (run_en) state_d = WR_PL;
            WR_PL:    state_d = WR_PH;
            WR_PH:    state_d = WR_START;
            WR_START: state_d = RUN;
            RUN: begin
                if (tm_irq) begin
                    state_d = CLR;
                end else if (!run_en) begin
                    state_d = WR_STOP;
                end else if (pend_load_q) begin
                    // A period write stops the timer, so reload goes through a full restart.
                    state_d = WR_PL;
                end
            end
            CLR:      state_d = SETTLE;
            SETTLE:   state_d = RUN;
            WR_STOP:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Capture requested periods (clamped, last request wins) and track pending reloads.
    always_comb begin
        period_d    = period_q;
        pend_load_d = pend_load_q;
        if (state_q == WR_PH) begin
            pend_load_d = 1'b0;
        end
        if (cfg_load) begin
            period_d    = (cfg_period < PERIOD_MIN) ? PERIOD_MIN : cfg_period;
            pend_load_d = 1'b1;
        end
    end

    // Registered bus and status outputs, decoded from the state being entered.
    always_comb begin
        tm_chipselect_d = 1'b0;
        tm_write_n_d    = 1'b1;
        tm_address_d    = 3'd0;
        tm_writedata_d  = 16'd0;
        busy_d          = 1'b0;
        running_d       = 1'b0;
        case (state_d)
            WR_PL: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = ADDR_PERIODL;
                tm_writedata_d  = period_d[15:0];
                busy_d          = 1'b1;
            end
            WR_PH: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = ADDR_PERIODH;
                tm_writedata_d  = period_d[31:16];
                busy_d          = 1'b1;
            end
            WR_START: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = ADDR_CONTROL;
                tm_writedata_d  = CTRL_START;
                busy_d          = 1'b1;
            end
            CLR: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = ADDR_STATUS;
                tm_writedata_d  = 16'd0;
            end
            WR_STOP: begin
                tm_chipselect_d = 1'b1;
                tm_write_n_d    = 1'b0;
                tm_address_d    = ADDR_CONTROL;
                tm_writedata_d  = CTRL_STOP;
                busy_d          = 1'b1;
            end
            RUN: begin
                running_d = 1'b1;
            end
            default: begin
                running_d = 1'b0;
            end
        endcase
    end

`ifdef GAME_TICK_PRESCALE_EN
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;

    // Count serviced irqs and tick only on every TICK_DIV-th one; restart counts on START.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (state_q == WR_START) begin
            presc_d = '0;
        end else if (state_q == CLR) begin
            if (presc_q == PRESC_LAST) begin
                tick_d  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Every serviced irq becomes a tick on the cycle after the status clear.
    always_comb begin
        tick_d = (state_q == CLR);
    end
`endif

    // Tick counter advances together with the tick pulse and wraps naturally.
    always_comb begin
        tick_count_d = tick_d ? (tick_count_q + 16'd1) : tick_count_q;
    end

    // State, configuration and output registers; reset idles the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            period_q        <= DEFAULT_PERIOD;
            pend_load_q     <= 1'b0;
            tm_address_q    <= 3'd0;
            tm_chipselect_q <= 1'b0;
            tm_write_n_q    <= 1'b1;
            tm_writedata_q  <= 16'd0;
            tick_q          <= 1'b0;
            tick_count_q    <= 16'd0;
            busy_q          <= 1'b0;
            running_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            period_q        <= period_d;
            pend_load_q     <= pend_load_d;
            tm_address_q    <= tm_address_d;
            tm_chipselect_q <= tm_chipselect_d;
            tm_write_n_q    <= tm_write_n_d;
            tm_writedata_q  <= tm_writedata_d;
            tick_q          <= tick_d;
            tick_count_q    <= tick_count_d;
            busy_q          <= busy_d;
            running_q       <= running_d;
        end
    end

    assign tm_address    = tm_address_q;
    assign tm_chipselect = tm_chipselect_q;
    assign tm_write_n    = tm_write_n_q;
    assign tm_writedata  = tm_writedata_q;
    assign tick          = tick_q;
    assign tick_count    = tick_count_q;
    assign busy          = busy_q;
    assign running       = running_q;

endmodule
